// File: rtl/lisnoc_router_pkg.sv
// lisnoc_router_pkg: flit type encoding, VC arbitration modes and width helpers shared by the router output port
package lisnoc_router_pkg;
   localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
   localparam logic [1:0] FLIT_HEADER  = 2'b01;
   localparam logic [1:0] FLIT_LAST    = 2'b10;
   localparam logic [1:0] FLIT_SINGLE  = 2'b11;
   localparam int VC_ARB_RR   = 0;
   localparam int VC_ARB_PRIO = 1;
   typedef enum logic {IN_IDLE, IN_LOCKED} in_state_t;
   function automatic int flit_width(input int data_w, input int type_w);
      return data_w + type_w;
   endfunction
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/lisnoc_router_output_vcarb_if.sv
// lisnoc_router_output_vcarb_if: switch-side request/flit/read bus and link-side flit/valid/ready plus occupancy
interface lisnoc_router_output_vcarb_if #(
   parameter int flit_width = 34,
   parameter int ports      = 5,
   parameter int vchannels  = 2,
   parameter int cw         = 3
);
   logic [ports*vchannels-1:0]            switch_request;
   logic [flit_width*ports*vchannels-1:0] switch_flit;
   logic [ports*vchannels-1:0]            switch_read;
   logic [flit_width-1:0]                 link_flit;
   logic [vchannels-1:0]                  link_valid;
   logic [vchannels-1:0]                  link_ready;
   logic [vchannels*cw-1:0]               fifo_count;
   modport master (
      output switch_request, switch_flit, link_ready,
      input  switch_read, link_flit, link_valid, fifo_count
   );
   modport slave (
      input  switch_request, switch_flit, link_ready,
      output switch_read, link_flit, link_valid, fifo_count
   );
endinterface

// File: rtl/lisnoc_rr_arbiter.sv
// lisnoc_rr_arbiter: round-robin arbiter whose search starts just after the last consumed grant
module lisnoc_rr_arbiter #(
   parameter int n = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n-1:0] req_i,
   input  logic         advance_i,
   output logic [n-1:0] gnt_o
);
   localparam int PW = n > 1 ? $clog2(n) : 1;
   logic [PW-1:0] ptr_q, ptr_d, nxt, idx;
   // Scan backwards from the far end so the requester nearest the pointer is the one left granted
   always_comb begin
      gnt_o = '0;
      nxt   = ptr_q;
      idx   = '0;
      for (int i = n - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr_q) + i) % n);
         if (req_i[idx]) begin
            gnt_o      = '0;
            gnt_o[idx] = 1'b1;
            nxt        = PW'((int'(ptr_q) + i + 1) % n);
         end
      end
      ptr_d = advance_i ? nxt : ptr_q;
   end
   // Pointer moves past the winner only when the grant is actually consumed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
endmodule

// File: rtl/lisnoc_router_output_vcarb.sv
// lisnoc_router_output_vcarb: per-VC wormhole input arbitration, per-VC FIFOs and VC-to-link arbitration;
// define LISNOC_OUTPUT_BYPASS_EN to let a flit skip an empty FIFO straight onto the link
module lisnoc_router_output_vcarb
   import lisnoc_router_pkg::*;
#(
   parameter int flit_data_width = 32,
   parameter int flit_type_width = 2,
   parameter int ports           = 5,
   parameter int vchannels       = 2,
   parameter int fifo_length     = 4,
   parameter int vc_arb_mode     = VC_ARB_RR
) (
   input logic clk,
   input logic rst,
   lisnoc_router_output_vcarb_if.slave bus
);
   localparam int FW = flit_width(flit_data_width, flit_type_width);
   localparam int CW = count_width(fifo_length);
   localparam int AW = fifo_length > 1 ? $clog2(fifo_length) : 1;
   localparam int PW = ports > 1 ? $clog2(ports) : 1;
`ifdef LISNOC_OUTPUT_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   logic [vchannels-1:0]         head_valid, elig, win;
   logic [vchannels-1:0][FW-1:0] head_flit;
   for (genvar v = 0; v < vchannels; v++) begin : g_vc
      logic [ports-1:0]         req, arb_req, gnt;
      logic [ports-1:0][FW-1:0] flits;
      logic [FW-1:0]            sel_flit;
      logic [FW-1:0]            mem_q [fifo_length];
      logic [AW-1:0]            rd_q, wr_q;
      logic [CW-1:0]            cnt_q;
      logic [PW-1:0]            lport_q, lport_d, gidx;
      in_state_t                state_q, state_d;
      logic                     full, empty, acc, adv, wr, pop;
      // Unpack this VC's slots; a locked VC only listens to its owner, an idle one only to packet starts
      always_comb begin
         req     = '0;
         flits   = '0;
         arb_req = '0;
         for (int p = 0; p < ports; p++) begin
            req[p]     = bus.switch_request[p*vchannels+v];
            flits[p]   = bus.switch_flit[(p*vchannels+v)*FW +: FW];
            arb_req[p] = state_q == IN_LOCKED ? req[p] && lport_q == PW'(p)
                                              : req[p] && flits[p][FW-1 -: 2] inside {FLIT_HEADER, FLIT_SINGLE};
         end
      end
      lisnoc_rr_arbiter #(.n(ports)) u_in_arb (
         .clk       (clk),
         .rst       (rst),
         .req_i     (arb_req),
         .advance_i (adv),
         .gnt_o     (gnt)
      );
      assign empty = cnt_q == '0;
      assign full  = cnt_q == CW'(fifo_length);
      assign acc   = |gnt && !full && !rst;
      // Pick the granted flit and step the wormhole lock; pointer advances only when a packet ends
      always_comb begin
         sel_flit = '0;
         gidx     = '0;
         for (int p = 0; p < ports; p++) begin
            if (gnt[p]) begin
               sel_flit = flits[p];
               gidx     = PW'(p);
            end
         end
         state_d = state_q;
         lport_d = lport_q;
         adv     = 1'b0;
         if (acc && state_q == IN_LOCKED) begin
            adv     = sel_flit[FW-1 -: 2] == FLIT_LAST;
            state_d = adv ? IN_IDLE : IN_LOCKED;
         end else if (acc) begin
            adv     = sel_flit[FW-1 -: 2] == FLIT_SINGLE;
            state_d = sel_flit[FW-1 -: 2] == FLIT_HEADER ? IN_LOCKED : IN_IDLE;
            lport_d = gidx;
         end
      end
      for (genvar p = 0; p < ports; p++) begin : g_rd
         assign bus.switch_read[p*vchannels+v] = gnt[p] && acc;
      end
      assign pop                         = win[v] && !empty;
      assign wr                          = acc && !(win[v] && empty);
      assign head_valid[v]               = !empty || (BYPASS && acc);
      assign head_flit[v]                = !empty ? mem_q[rd_q] : BYPASS ? sel_flit : '0;
      assign bus.fifo_count[v*CW +: CW]  = cnt_q;
      // Lock state and FIFO pointers; a full FIFO refuses writes even while it is being popped
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= IN_IDLE;
            lport_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            lport_q <= lport_d;
            if (pop) rd_q <= rd_q == AW'(fifo_length - 1) ? '0 : rd_q + AW'(1);
            if (wr)  wr_q <= wr_q == AW'(fifo_length - 1) ? '0 : wr_q + AW'(1);
            cnt_q   <= cnt_q + CW'(wr) - CW'(pop);
         end
      end
      // Storage needs no reset: occupancy gates every read
      always_ff @(posedge clk) begin
         if (wr) mem_q[wr_q] <= sel_flit;
      end
   end
   assign elig = head_valid & bus.link_ready;
   if (vc_arb_mode == VC_ARB_RR) begin : g_rr
      lisnoc_rr_arbiter #(.n(vchannels)) u_vc_arb (
         .clk       (clk),
         .rst       (rst),
         .req_i     (elig),
         .advance_i (|elig),
         .gnt_o     (win)
      );
   end else begin : g_prio
      // Highest eligible VC index wins
      always_comb begin
         win = '0;
         for (int i = 0; i < vchannels; i++) begin
            if (elig[i]) begin
               win    = '0;
               win[i] = 1'b1;
            end
         end
      end
   end
   // Drive the link with the winning head; zero when nothing transfers
   always_comb begin
      bus.link_flit = '0;
      for (int i = 0; i < vchannels; i++) begin
         if (win[i]) bus.link_flit = head_flit[i];
      end
   end
   assign bus.link_valid = win;
endmodule

// File: tb/tb_lisnoc_router_output_vcarb.sv
// tb_lisnoc_router_output_vcarb: round-robin and fixed-priority instances checked every cycle against a queue-based model
module tb_lisnoc_router_output_vcarb;
   import lisnoc_router_pkg::*;
   localparam int P  = 5;
   localparam int V  = 2;
   localparam int L  = 3;
   localparam int DW = 32;
   localparam int FW = 34;
   localparam int CW = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [P*V-1:0]    req    [2];
   logic [FW*P*V-1:0] flit   [2];
   logic [V-1:0]      ready;
   logic [P*V-1:0]    d_read [2];
   logic [V-1:0]      d_valid[2];
   logic [FW-1:0]     d_flit [2];
   logic [V*CW-1:0]   d_cnt  [2];
   logic [FW-1:0]     mq  [2][V][$];
   logic [FW-1:0]     src [2][P*V][$];
   int lock [2][V];
   int rrp  [2][V];
   int vcp  [2];
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   lisnoc_router_output_vcarb_if #(.flit_width(FW), .ports(P), .vchannels(V), .cw(CW)) bif0 ();
   lisnoc_router_output_vcarb_if #(.flit_width(FW), .ports(P), .vchannels(V), .cw(CW)) bif1 ();
   assign bif0.switch_request = req[0];
   assign bif0.switch_flit    = flit[0];
   assign bif0.link_ready     = ready;
   assign bif1.switch_request = req[1];
   assign bif1.switch_flit    = flit[1];
   assign bif1.link_ready     = ready;
   assign d_read[0]  = bif0.switch_read;
   assign d_valid[0] = bif0.link_valid;
   assign d_flit[0]  = bif0.link_flit;
   assign d_cnt[0]   = bif0.fifo_count;
   assign d_read[1]  = bif1.switch_read;
   assign d_valid[1] = bif1.link_valid;
   assign d_flit[1]  = bif1.link_flit;
   assign d_cnt[1]   = bif1.fifo_count;
   lisnoc_router_output_vcarb #(.flit_data_width(DW), .flit_type_width(2), .ports(P), .vchannels(V),
      .fifo_length(L), .vc_arb_mode(VC_ARB_RR)) dut_rr (.clk(clk), .rst(rst), .bus(bif0));
   lisnoc_router_output_vcarb #(.flit_data_width(DW), .flit_type_width(2), .ports(P), .vchannels(V),
      .fifo_length(L), .vc_arb_mode(VC_ARB_PRIO)) dut_pr (.clk(clk), .rst(rst), .bus(bif1));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_idle(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_read%0d", tag, i), 64'(d_read[i]), 64'd0);
         chk($sformatf("%s_valid%0d", tag, i), 64'(d_valid[i]), 64'd0);
         chk($sformatf("%s_flit%0d", tag, i), 64'(d_flit[i]), 64'd0);
         chk($sformatf("%s_cnt%0d", tag, i), 64'(d_cnt[i]), 64'd0);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         vcp[i] = 0;
         for (int v = 0; v < V; v++) begin
            mq[i][v].delete();
            lock[i][v] = -1;
            rrp[i][v]  = 0;
         end
         for (int s = 0; s < P*V; s++) src[i][s].delete();
      end
   endtask
   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         for (int s = 0; s < P*V; s++) begin
            req[i][s] = src[i][s].size() > 0;
            flit[i][s*FW +: FW] = '0;
            if (req[i][s]) flit[i][s*FW +: FW] = src[i][s][0];
         end
      end
   endtask
   // Expected outputs for this cycle from the current model state, then advance the model past the edge
   task automatic eval(input int i);
      int g [V];
      int sz [V];
      int w, c, p, s;
      logic [P*V-1:0]  e_read;
      logic [V-1:0]    hv, e_valid;
      logic [FW-1:0]   hf [V];
      logic [FW-1:0]   f, e_flit;
      logic [V*CW-1:0] e_cnt;
      logic [1:0]      t;
      e_read = '0;
      e_cnt  = '0;
      for (int v = 0; v < V; v++) begin
         c = -1;
         if (lock[i][v] >= 0) begin
            if (req[i][lock[i][v]*V+v]) c = lock[i][v];
         end else begin
            for (int k = 0; k < P; k++) begin
               p = (rrp[i][v] + k) % P;
               t = flit[i][(p*V+v)*FW + DW +: 2];
               if (c < 0 && req[i][p*V+v] && (t == FLIT_HEADER || t == FLIT_SINGLE)) c = p;
            end
         end
         sz[v] = mq[i][v].size();
         g[v]  = (c >= 0 && sz[v] < L) ? c : -1;
         if (g[v] >= 0) e_read[g[v]*V+v] = 1'b1;
         hv[v] = sz[v] > 0;
         hf[v] = '0;
         if (hv[v]) hf[v] = mq[i][v][0];
`ifdef LISNOC_OUTPUT_BYPASS_EN
         if (!hv[v] && g[v] >= 0) begin
            hv[v] = 1'b1;
            hf[v] = flit[i][(g[v]*V+v)*FW +: FW];
         end
`endif
         e_cnt[v*CW +: CW] = CW'(sz[v]);
      end
      w = -1;
      for (int k = 0; k < V; k++) begin
         if (i == 1) begin
            if (hv[k] && ready[k]) w = k;
         end else begin
            s = (vcp[i] + k) % V;
            if (w < 0 && hv[s] && ready[s]) w = s;
         end
      end
      e_valid = '0;
      e_flit  = '0;
      if (w >= 0) begin
         e_valid[w] = 1'b1;
         e_flit     = hf[w];
      end
      chk($sformatf("switch_read%0d", i), 64'(d_read[i]), 64'(e_read));
      chk($sformatf("link_valid%0d", i), 64'(d_valid[i]), 64'(e_valid));
      chk($sformatf("link_flit%0d", i), 64'(d_flit[i]), 64'(e_flit));
      chk($sformatf("fifo_count%0d", i), 64'(d_cnt[i]), 64'(e_cnt));
      if (w >= 0) begin
         if (sz[w] > 0) void'(mq[i][w].pop_front());
         vcp[i] = (w + 1) % V;
      end
      for (int v = 0; v < V; v++) begin
         if (g[v] >= 0) begin
            f = flit[i][(g[v]*V+v)*FW +: FW];
            t = f[FW-1 -: 2];
            if (!(w == v && sz[v] == 0)) mq[i][v].push_back(f);
            if (lock[i][v] >= 0) begin
               if (t == FLIT_LAST) begin
                  lock[i][v] = -1;
                  rrp[i][v]  = (g[v] + 1) % P;
               end
            end else if (t == FLIT_HEADER) lock[i][v] = g[v];
            else rrp[i][v] = (g[v] + 1) % P;
            void'(src[i][g[v]*V+v].pop_front());
         end
      end
   endtask
   task automatic step();
      drive();
      #1;
      eval(0);
      eval(1);
      @(negedge clk);
   endtask
   task automatic run(input int n);
      repeat (n) step();
   endtask
   task automatic push_pkt(input int p, input int v, input int len);
      logic [FW-1:0] f;
      for (int k = 0; k < len; k++) begin
         f[DW-1:0]    = $urandom();
         f[FW-1 -: 2] = len == 1 ? FLIT_SINGLE : k == 0 ? FLIT_HEADER : k == len - 1 ? FLIT_LAST : FLIT_PAYLOAD;
         for (int i = 0; i < 2; i++) src[i][p*V+v].push_back(f);
      end
   endtask
   initial begin
      int rp, rv, rl;
      ready = '0;
      model_reset();
      drive();
      #1;
      chk_idle("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      // Wormhole lock: port 1 packet completes before port 3 header
      ready = 2'b11;
      push_pkt(1, 0, 3);
      step();
      push_pkt(3, 0, 2);
      run(12);
      // Full FIFO holds the 4th single until a pop frees a slot
      ready = 2'b00;
      for (int p = 0; p < 4; p++) push_pkt(p, 1, 1);
      run(6);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("full_cnt%0d", i), 64'(d_cnt[i][CW +: CW]), 64'd3);
         chk($sformatf("full_held%0d", i), 64'(d_read[i]), 64'd0);
      end
      ready = 2'b10;
      run(8);
      // Both VCs backlogged: alternation vs. priority
      ready = 2'b00;
      for (int p = 0; p < 4; p++) begin
         push_pkt(p, 0, 1);
         push_pkt(p, 1, 1);
      end
      run(6);
      ready = 2'b11;
      run(14);
      // Ready low on the only nonempty VC blocks the link
      ready = 2'b00;
      push_pkt(4, 1, 1);
      run(2);
      ready = 2'b01;
      run(3);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("blocked_valid%0d", i), 64'(d_valid[i]), 64'd0);
         chk($sformatf("blocked_cnt%0d", i), 64'(d_cnt[i][CW +: CW]), 64'd1);
      end
      ready = 2'b11;
      run(3);
      // Reset in the middle of a locked packet
      ready = 2'b00;
      push_pkt(2, 0, 5);
      run(2);
      for (int i = 0; i < 2; i++) chk($sformatf("prerst_cnt%0d", i), 64'(d_cnt[i][CW-1:0]), 64'd2);
      rst = 1'b1;
      #1;
      chk_idle("midrst");
      model_reset();
      drive();
      @(negedge clk);
      rst = 1'b0;
      push_pkt(4, 0, 2);
      ready = 2'b11;
      run(6);
      // Random traffic and backpressure
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) begin
            rp = $urandom_range(0, P - 1);
            rv = $urandom_range(0, V - 1);
            rl = $urandom_range(1, 4);
            push_pkt(rp, rv, rl);
         end
         ready = V'($urandom());
         step();
      end
      ready = 2'b11;
      run(200);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lisnoc_router_output_vcarb.md
Name: lisnoc_router_output_vcarb

Overview:
- Next-generation router output port: per-VC wormhole input arbitration across switch ports, per-VC buffering, and a selectable VC-to-link arbitration mode.
- Adds packet locking on the input arbiter, per-VC occupancy reporting, and optional empty-FIFO bypass.
- Sits between the router switch fabric and one outgoing link.
- Flit type field uses the codebase encoding: PAYLOAD=2'b00, HEADER=2'b01, LAST=2'b10, SINGLE=2'b11.

Parameters:
flit_data_width, 32, data bits per flit
flit_type_width, 2, type bits (MSBs of flit); fixed at 2
ports, 5, switch inputs competing for this output
vchannels, 2, virtual channels (>=1)
fifo_length, 4, per-VC FIFO depth (>=1, any integer)
vc_arb_mode, 0, 0 = round-robin over VCs per flit; 1 = fixed priority, highest VC index wins

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
switch_request  in  ports*vchannels  request, bit index p*vchannels+v
switch_flit  in  flit_width*ports*vchannels  flit for slot p*vchannels+v
switch_read  out  ports*vchannels  accept strobe, same indexing
link_flit  out  flit_width  outgoing flit
link_valid  out  vchannels  one-hot/zero: VC carrying link_flit
link_ready  in  vchannels  per-VC sink accept
fifo_count  out  vchannels*CW  per-VC occupancy, CW=$clog2(fifo_length+1)

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, fifo_count=0, input locks cleared, RR pointers at port 0 / VC 0, switch_read=0, link_valid=0, link_flit=0 (a don't-care is not acceptable).
- Input arbitration, per VC v, independent:
  - States IDLE and LOCKED(p).
  - IDLE: round-robin among ports with request whose flit type is HEADER or SINGLE. Search starts at the port after the last winner. PAYLOAD/LAST requests from an unlocked port are ignored.
  - Grant p and FIFO not full -> switch_read[p*vchannels+v]=1 in the same cycle (combinational) and the flit is written at the clock edge.
  - HEADER accepted -> LOCKED(p). SINGLE accepted -> stay IDLE; pointer advances.
  - LOCKED(p): only port p is served. LAST accepted -> IDLE, pointer advances past p.
  - At most one switch_read bit set per VC per cycle.
  - FIFO full -> no read. Lock and pointer hold.
- FIFO, per VC:
  - Registered storage, first-word visible the cycle after write.
  - Simultaneous read+write when full is legal: the read frees a slot only in the next cycle, so the write is refused that cycle.
  - Simultaneous read+write when empty is covered under Optional Feature.
  - fifo_count updates on the clock edge: +1 on write, -1 on read, unchanged on both.
- Output arbitration (combinational select, registered state):
  - Eligible VC = FIFO head valid AND link_ready[v].
  - Mode 0: round-robin from the VC after the last transferred VC. Pointer updates only on transfer.
  - Mode 1: highest eligible index.
  - Winner w: link_valid[w]=1, link_flit = head of w, FIFO w popped at the edge. No eligible VC -> link_valid=0, link_flit=0.
  - link_valid never asserts on a VC whose link_ready is low.
  - Transfer of an idle-link flit (FIFO written at edge N) appears at link in cycle N+1.
- Reset mid-packet: locks drop; partially buffered flits are discarded. Upstream must also reset.
- Wrap-around: FIFO pointers wrap mod fifo_length. Non-power-of-two depths must work.

Optional Feature:
- Macro: LISNOC_OUTPUT_BYPASS_EN.
- Defined: when FIFO v is empty, a flit accepted from the switch may go straight to the link in the same cycle, provided v wins output arbitration (its link_ready is high). In that case it is not written into the FIFO and fifo_count stays 0. The switch-to-link path is then combinational.
- Undefined: always buffered. Minimum latency is 1 cycle, and no combinational path exists from switch_request/switch_flit to link_*.

Decomposition:
- Package lisnoc_router_pkg:
  - flit type constants FLIT_PAYLOAD/HEADER/LAST/SINGLE
  - flit width helper
  - arbitration mode constants VC_ARB_RR=0 and VC_ARB_PRIO=1
- Sub-module lisnoc_rr_arbiter (parameter n; req, advance -> one-hot gnt; pointer register). It is instantiated per VC for input arbitration and once for mode-0 VC arbitration.
- FIFO is inline or reuses the existing codebase FIFO only if that FIFO supports arbitrary depth and an occupancy output.

Test Plan:
- ports=5, vchannels=2: port 1 sends HEADER, PAYLOAD, LAST on VC0 while port 3 sends HEADER on VC0 from cycle 1 -> all three port-1 flits read before any port-3 read. link shows 1H,1P,1L,3H in order.
- fifo_length=3, link_ready=0, 4 SINGLE flits on VC1 -> 3 reads, fifo_count[1]=3, 4th request held. Raise link_ready[1] -> 4th read occurs one cycle after first pop.
- vc_arb_mode=0, both VC FIFOs holding 4 flits, link_ready=2'b11 -> link_valid alternates 01,10,01,10. With mode=1 -> four 10 followed by four 01.
- link_ready=2'b01 with only VC1 nonempty -> link_valid=0, fifo_count[1] unchanged.
- Assert rst for 1 cycle mid-packet (LOCKED on VC0, 2 flits buffered) -> immediate fifo_count=0, link_valid=0. Next HEADER from any port accepted.
- With LISNOC_OUTPUT_BYPASS_EN, empty FIFOs, SINGLE on port 0 VC0 with link_ready=1 -> switch_read and link_valid[0] in the same cycle, fifo_count stays 0. Without the macro -> link_valid one cycle later.
